// File: rtl/macarray_pkg.sv
// Shared definitions for the 4x4 MAC-array sequencer.
//   - FSM state encoding
//   - tiling constants and derived counter widths
//   - helpers that slice and range-check the packed {M,N,T} dimension word
package macarray_pkg;

  localparam int ARR           = 4;  // array edge
  localparam int MAX_DIM       = 8;  // largest legal M/N/T
  localparam int STRIP_STRIDE  = 8;  // buffer words per row/col strip
  localparam int TILE_T_STRIDE = 4;  // O words per tile along T

  localparam int DIM_W  = 4;
  localparam int K_W    = $clog2(MAX_DIM);
  localparam int TILE_W = $clog2(MAX_DIM / ARR);
  localparam int ROW_W  = $clog2(ARR);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, WRITE, FIN} state_t;

  function automatic logic [DIM_W-1:0] mnt_m(input logic [11:0] mnt);
    return mnt[11:8];
  endfunction

  function automatic logic [DIM_W-1:0] mnt_n(input logic [11:0] mnt);
    return mnt[7:4];
  endfunction

  function automatic logic [DIM_W-1:0] mnt_t(input logic [11:0] mnt);
    return mnt[3:0];
  endfunction

  function automatic logic dim_ok(input logic [DIM_W-1:0] d, input int max_dim);
    return (d != '0) && (int'(d) <= max_dim);
  endfunction

endpackage

// File: rtl/macarray_addr_gen.sv
// Buffer address generation for the MAC-array sequencer (purely combinational).
//   mi, ti : tile coordinates (row strip, column strip)
//   k      : reduction index within the current tile
//   r      : output row within the current tile
//   addr_i : I buffer address, column k of row-strip mi
//   addr_w : W buffer address, row k of col-strip ti
//   addr_o : O buffer address, row r of tile (mi, ti)
module macarray_addr_gen
  import macarray_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic [TILE_W-1:0] mi,
  input  logic [TILE_W-1:0] ti,
  input  logic [K_W-1:0]    k,
  input  logic [ROW_W-1:0]  r,
  output logic [AW-1:0]     addr_i,
  output logic [AW-1:0]     addr_w,
  output logic [AW-1:0]     addr_o
);

  always_comb begin
    addr_i = AW'(int'(mi) * STRIP_STRIDE + int'(k));
    addr_w = AW'(int'(ti) * STRIP_STRIDE + int'(k));
    addr_o = AW'(int'(mi) * STRIP_STRIDE + int'(ti) * TILE_T_STRIDE + int'(r));
  end

endmodule

// File: rtl/macarray_ctrl.sv
// Sequencer for the 4x4 MAC-array datapath.
// Latches {M,N,T} on START, walks the output matrix tile by tile (ti fastest):
// LOAD streams k=0..N-1 reads from I/W, WAIT drains the 1-cycle buffer
// latency, WRITE stores min(4, M-4*mi) accumulator rows to O, FIN pulses DONE.
// Ports:
//   CLK, RST          clock, async active-high reset
//   START, MNT        job request and packed {M,N,T}
//   BUSY, DONE, ERR   job status (ERR pulses with DONE for illegal MNT)
//   EN_I/ADDR_I       I buffer read port
//   EN_W/ADDR_W       W buffer read port
//   MAC_VLD, MAC_CLR  datapath accumulate / first-product strobes
//   ROW_SEL           accumulator row driven onto the O write data
//   EN_O/RW_O/ADDR_O  O buffer write port
//   CYC_CNT           job cycle counter, only with MACARRAY_CTRL_PERF_EN
// Build option: define MACARRAY_CTRL_PERF_EN to add the CYC_CNT counter.
module macarray_ctrl #(
  parameter int ARR     = 4,
  parameter int MAX_DIM = 8,
  parameter int AW      = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [11:0]   MNT,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic          EN_I,
  output logic [AW-1:0] ADDR_I,
  output logic          EN_W,
  output logic [AW-1:0] ADDR_W,
  output logic          MAC_VLD,
  output logic          MAC_CLR,
  output logic [1:0]    ROW_SEL,
  output logic          EN_O,
  output logic          RW_O,
  output logic [AW-1:0] ADDR_O
`ifdef MACARRAY_CTRL_PERF_EN
  ,
  output logic [15:0]   CYC_CNT
`endif
);

  import macarray_pkg::*;

  state_t state, state_nx;

  logic [DIM_W-1:0]  m_q, n_q, t_q;
  logic              err_q;
  logic [TILE_W-1:0] mi, ti;
  logic [K_W-1:0]    k;
  logic [ROW_W-1:0]  r;
  logic              mac_vld_q, mac_clr_q;

  logic              accept, mnt_ok;
  logic              k_last, r_last, mi_last, ti_last;
  logic [DIM_W-1:0]  m_rem, m_rem_m1;
  logic [ROW_W-1:0]  rows_last;
  logic [AW-1:0]     a_i, a_w, a_o;

  assign accept = (state == IDLE) && START;
  assign mnt_ok = dim_ok(mnt_m(MNT), MAX_DIM) && dim_ok(mnt_n(MNT), MAX_DIM) &&
                  dim_ok(mnt_t(MNT), MAX_DIM);

  // Rows left below this row strip; the last strip may be partial.
  assign m_rem     = m_q - DIM_W'(ARR * int'(mi));
  assign m_rem_m1  = m_rem - DIM_W'(1);
  assign rows_last = (m_rem >= DIM_W'(ARR)) ? ROW_W'(ARR - 1) : ROW_W'(m_rem_m1);

  assign k_last  = (DIM_W'(k) == n_q - DIM_W'(1));
  assign r_last  = (r == rows_last);
  // Last tile index along a dimension is ceil(d/ARR)-1 == (d-1)/ARR.
  assign mi_last = (DIM_W'(mi) == (m_q - DIM_W'(1)) / DIM_W'(ARR));
  assign ti_last = (DIM_W'(ti) == (t_q - DIM_W'(1)) / DIM_W'(ARR));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (START) state_nx = mnt_ok ? LOAD : FIN;
      LOAD:  if (k_last) state_nx = WAIT;
      WAIT:  state_nx = WRITE;
      WRITE: if (r_last) state_nx = (mi_last && ti_last) ? FIN : LOAD;
      FIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_q   <= '0;
      n_q   <= '0;
      t_q   <= '0;
      err_q <= 1'b0;
      mi    <= '0;
      ti    <= '0;
      k     <= '0;
      r     <= '0;
    end else begin
      case (state)
        IDLE: if (START) begin
          m_q   <= mnt_m(MNT);
          n_q   <= mnt_n(MNT);
          t_q   <= mnt_t(MNT);
          err_q <= !mnt_ok;
          mi    <= '0;
          ti    <= '0;
          k     <= '0;
          r     <= '0;
        end
        LOAD: k <= k_last ? '0 : k + K_W'(1);
        WAIT: r <= '0;
        WRITE: begin
          if (r_last) begin
            r <= '0;
            if (!(mi_last && ti_last)) begin
              if (ti_last) begin
                ti <= '0;
                mi <= mi + TILE_W'(1);
              end else begin
                ti <= ti + TILE_W'(1);
              end
            end
          end else begin
            r <= r + ROW_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Read data shows up one cycle after the enable; CLR marks the k=0 product.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mac_vld_q <= 1'b0;
      mac_clr_q <= 1'b0;
    end else begin
      mac_vld_q <= (state == LOAD);
      mac_clr_q <= (state == LOAD) && (k == '0);
    end
  end

  macarray_addr_gen #(.AW(AW)) u_addr (
    .mi     (mi),
    .ti     (ti),
    .k      (k),
    .r      (r),
    .addr_i (a_i),
    .addr_w (a_w),
    .addr_o (a_o)
  );

  // Addresses and row select are forced to 0 while their port is idle.
  assign BUSY    = (state != IDLE);
  assign DONE    = (state == FIN);
  assign ERR     = (state == FIN) && err_q;
  assign EN_I    = (state == LOAD);
  assign EN_W    = (state == LOAD);
  assign ADDR_I  = EN_I ? a_i : '0;
  assign ADDR_W  = EN_W ? a_w : '0;
  assign MAC_VLD = mac_vld_q;
  assign MAC_CLR = mac_clr_q;
  assign EN_O    = (state == WRITE);
  assign RW_O    = (state == WRITE);
  assign ROW_SEL = EN_O ? 2'(r) : 2'b00;
  assign ADDR_O  = EN_O ? a_o : '0;

`ifdef MACARRAY_CTRL_PERF_EN
  // Counts the accept cycle plus every BUSY cycle, so a job that errors out
  // straight away reads 2. Holds after FIN until the next accept.
  logic [15:0] cyc_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                              cyc_q <= '0;
    else if (accept)                      cyc_q <= 16'd1;
    else if (BUSY && cyc_q != 16'hFFFF)   cyc_q <= cyc_q + 16'd1;
  end

  assign CYC_CNT = cyc_q;
`else
  // No cycle counter in this build; accept is only consumed by the FSM.
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_macarray_ctrl.sv
module tb_macarray_ctrl;

  logic        CLK = 1'b0;
  logic        RST, START;
  logic [11:0] MNT;
  logic        BUSY, DONE, ERR, EN_I, EN_W, MAC_VLD, MAC_CLR, EN_O, RW_O;
  logic [3:0]  ADDR_I, ADDR_W, ADDR_O;
  logic [1:0]  ROW_SEL;
`ifdef MACARRAY_CTRL_PERF_EN
  logic [15:0] CYC_CNT;
`endif

  macarray_ctrl dut (
    .CLK(CLK), .RST(RST), .START(START), .MNT(MNT),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .EN_I(EN_I), .ADDR_I(ADDR_I), .EN_W(EN_W), .ADDR_W(ADDR_W),
    .MAC_VLD(MAC_VLD), .MAC_CLR(MAC_CLR), .ROW_SEL(ROW_SEL),
    .EN_O(EN_O), .RW_O(RW_O), .ADDR_O(ADDR_O)
`ifdef MACARRAY_CTRL_PERF_EN
    , .CYC_CNT(CYC_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  // flag order: {BUSY,DONE,ERR,EN_I,EN_W,MAC_VLD,MAC_CLR,EN_O,RW_O}
  localparam logic [8:0] F_IDLE = 9'b000000000;
  localparam logic [8:0] F_LD0  = 9'b100110000;
  localparam logic [8:0] F_LD1  = 9'b100111100;
  localparam logic [8:0] F_LDN  = 9'b100111000;
  localparam logic [8:0] F_WT   = 9'b100001000;
  localparam logic [8:0] F_WR   = 9'b100000011;
  localparam logic [8:0] F_FIN  = 9'b110000000;
  localparam logic [8:0] F_ERR  = 9'b111000000;

  typedef struct {
    logic [11:0] mnt;
    int          cyc;
    logic [8:0]  f;
    logic [3:0]  ai, aw, ao;
    logic [1:0]  rs;
  } vec_t;

  typedef struct {
    logic [11:0] mnt;
    int          done_cyc;
    int          writes;
    int          reads;
  } job_t;

  localparam int TRC = 70;
  logic [8:0] tr_f  [0:TRC-1];
  logic [3:0] tr_ai [0:TRC-1];
  logic [3:0] tr_aw [0:TRC-1];
  logic [3:0] tr_ao [0:TRC-1];
  logic [1:0] tr_rs [0:TRC-1];
  int done_cyc, wr_cnt, rd_cnt;

  int checks = 0;
  int failures = 0;

  vec_t vt[$];
  job_t jt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] flags();
    return {BUSY, DONE, ERR, EN_I, EN_W, MAC_VLD, MAC_CLR, EN_O, RW_O};
  endfunction

  // One-cycle START, then record outputs per cycle until the cycle after DONE.
  task automatic run_job(input logic [11:0] mnt);
    for (int i = 0; i < TRC; i++) begin
      tr_f[i] = 'x; tr_ai[i] = 'x; tr_aw[i] = 'x; tr_ao[i] = 'x; tr_rs[i] = 'x;
    end
    done_cyc = -1; wr_cnt = 0; rd_cnt = 0;
    @(negedge CLK);
    START = 1'b1;
    MNT   = mnt;
    for (int c = 1; c < TRC; c++) begin
      @(negedge CLK);
      if (c == 1) START = 1'b0;
      tr_f[c] = flags(); tr_ai[c] = ADDR_I; tr_aw[c] = ADDR_W;
      tr_ao[c] = ADDR_O; tr_rs[c] = ROW_SEL;
      if (EN_O) wr_cnt++;
      if (EN_I || EN_W) rd_cnt++;
      if (DONE && done_cyc < 0) done_cyc = c;
      if (done_cyc >= 0 && c > done_cyc) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn, d1, d2, w1, w2, ndone;
    logic [8:0] f11, f12;
    logic [3:0] a12;

    jt.push_back('{12'h444, 10, 4, 4});
    jt.push_back('{12'h888, 53, 16, 32});
    jt.push_back('{12'h535, 27, 10, 12});
    jt.push_back('{12'h094, 1, 0, 0});
    jt.push_back('{12'h9A1, 1, 0, 0});

    vt.push_back('{12'h444, 1,  F_LD0,  0, 0, 0, 0});
    vt.push_back('{12'h444, 2,  F_LD1,  1, 1, 0, 0});
    vt.push_back('{12'h444, 4,  F_LDN,  3, 3, 0, 0});
    vt.push_back('{12'h444, 5,  F_WT,   0, 0, 0, 0});
    vt.push_back('{12'h444, 6,  F_WR,   0, 0, 0, 0});
    vt.push_back('{12'h444, 9,  F_WR,   0, 0, 3, 3});
    vt.push_back('{12'h444, 10, F_FIN,  0, 0, 0, 0});
    vt.push_back('{12'h444, 11, F_IDLE, 0, 0, 0, 0});
    vt.push_back('{12'h888, 8,  F_LDN,  7, 7, 0, 0});
    vt.push_back('{12'h888, 9,  F_WT,   0, 0, 0, 0});
    vt.push_back('{12'h888, 13, F_WR,   0, 0, 3, 3});
    vt.push_back('{12'h888, 14, F_LD0,  0, 8, 0, 0});
    vt.push_back('{12'h888, 15, F_LD1,  1, 9, 0, 0});
    vt.push_back('{12'h888, 23, F_WR,   0, 0, 4, 0});
    vt.push_back('{12'h888, 34, F_LDN, 15, 7, 0, 0});
    vt.push_back('{12'h888, 40, F_LD0,  8, 8, 0, 0});
    vt.push_back('{12'h888, 52, F_WR,   0, 0, 15, 3});
    vt.push_back('{12'h888, 53, F_FIN,  0, 0, 0, 0});
    vt.push_back('{12'h535, 3,  F_LDN,  2, 2, 0, 0});
    vt.push_back('{12'h535, 4,  F_WT,   0, 0, 0, 0});
    vt.push_back('{12'h535, 8,  F_WR,   0, 0, 3, 3});
    vt.push_back('{12'h535, 9,  F_LD0,  0, 8, 0, 0});
    vt.push_back('{12'h535, 21, F_WR,   0, 0, 8, 0});
    vt.push_back('{12'h535, 22, F_LD0,  8, 8, 0, 0});
    vt.push_back('{12'h535, 26, F_WR,   0, 0, 12, 0});
    vt.push_back('{12'h535, 27, F_FIN,  0, 0, 0, 0});
    vt.push_back('{12'h094, 1,  F_ERR,  0, 0, 0, 0});
    vt.push_back('{12'h094, 2,  F_IDLE, 0, 0, 0, 0});
    vt.push_back('{12'h9A1, 1,  F_ERR,  0, 0, 0, 0});
    vt.push_back('{12'h9A1, 2,  F_IDLE, 0, 0, 0, 0});

    RST = 1'b1; START = 1'b0; MNT = '0;
    repeat (2) @(negedge CLK);
    chk("reset_flags", 32'(flags()), 32'(F_IDLE));
    chk("reset_addr", {20'd0, ADDR_I, ADDR_W, ADDR_O}, 32'd0);
    chk("reset_rowsel", 32'(ROW_SEL), 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    foreach (jt[j]) begin
      run_job(jt[j].mnt);
      chk($sformatf("done_cyc_%h", jt[j].mnt), done_cyc, jt[j].done_cyc);
      chk($sformatf("writes_%h", jt[j].mnt), wr_cnt, jt[j].writes);
      chk($sformatf("reads_%h", jt[j].mnt), rd_cnt, jt[j].reads);
`ifdef MACARRAY_CTRL_PERF_EN
      if (jt[j].writes == 0) chk($sformatf("cyc_cnt_%h", jt[j].mnt), CYC_CNT, 2);
`endif
      foreach (vt[v]) begin
        if (vt[v].mnt == jt[j].mnt) begin
          dn = vt[v].cyc;
          chk($sformatf("flags_%h_c%0d", vt[v].mnt, dn), tr_f[dn], vt[v].f);
          chk($sformatf("addr_i_%h_c%0d", vt[v].mnt, dn), tr_ai[dn], vt[v].ai);
          chk($sformatf("addr_w_%h_c%0d", vt[v].mnt, dn), tr_aw[dn], vt[v].aw);
          chk($sformatf("addr_o_%h_c%0d", vt[v].mnt, dn), tr_ao[dn], vt[v].ao);
          chk($sformatf("row_sel_%h_c%0d", vt[v].mnt, dn), tr_rs[dn], vt[v].rs);
        end
      end
    end

    // Reset in the middle of an 8x8x8 job.
    @(negedge CLK);
    START = 1'b1; MNT = 12'h888;
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      if (c == 1) START = 1'b0;
    end
    chk("pre_rst_flags", 32'(flags()), 32'(F_LDN));
    chk("pre_rst_addr_i", 32'(ADDR_I), 32'd4);
    #2 RST = 1'b1;
    #1;
    chk("rst_async_flags", 32'(flags()), 32'(F_IDLE));
    chk("rst_async_addr", {20'd0, ADDR_I, ADDR_W, ADDR_O}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    ndone = 0;
    repeat (60) begin
      @(negedge CLK);
      if (DONE || BUSY) ndone++;
    end
    chk("rst_no_done", ndone, 0);
    run_job(12'h888);
    chk("rerun_done_cyc", done_cyc, 53);
    chk("rerun_writes", wr_cnt, 16);
    chk("rerun_addr_o_c52", 32'(tr_ao[52]), 32'd15);

    // START held high, MNT changed mid-job.
    d1 = -1; d2 = -1; w1 = 0; w2 = 0; f11 = 'x; f12 = 'x; a12 = 'x;
    @(negedge CLK);
    START = 1'b1; MNT = 12'h444;
    for (int c = 1; c < TRC; c++) begin
      @(negedge CLK);
      if (c == 3) MNT = 12'h535;
      if (c == 13) START = 1'b0;
      if (c == 11) f11 = flags();
      if (c == 12) begin f12 = flags(); a12 = ADDR_W; end
      if (EN_O) begin
        if (d1 < 0) w1++;
        else w2++;
      end
      if (DONE) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      if (d2 >= 0 && c > d2) break;
    end
    chk("held_done1", d1, 10);
    chk("held_writes1", w1, 4);
    chk("held_fin_start_ignored", 32'(f11), 32'(F_IDLE));
    chk("held_relaunch_flags", 32'(f12), 32'(F_LD0));
    chk("held_relaunch_addr_w", 32'(a12), 32'd0);
    chk("held_done2", d2, 38);
    chk("held_writes2", w2, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
